// File: rtl/fir_channel_scheduler_if.sv
// Handshake and filter-side signals for fir_channel_scheduler.
// The master modport is the scheduler and the slave modport is its environment.
interface fir_channel_scheduler_if #(
    parameter int unsigned WIDTH = 16
);
    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             s0_ready;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_ready;
    logic             fir_clr_n;
    logic             fir_en;
    logic             fir_rin;
    logic [WIDTH-1:0] fir_din;
    logic [WIDTH-1:0] fir_result;
    logic             res_valid;
    logic             res_ch;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        input  s0_valid, s0_data, s1_valid, s1_data, fir_result,
        output s0_ready, s1_ready, fir_clr_n, fir_en, fir_rin, fir_din,
        output res_valid, res_ch, res_data, busy
    );

    modport slave (
        output s0_valid, s0_data, s1_valid, s1_data, fir_result,
        input  s0_ready, s1_ready, fir_clr_n, fir_en, fir_rin, fir_din,
        input  res_valid, res_ch, res_data, busy
    );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Time-shares one FIR filter between two sample channels in bursts. It clears the filter,
// streams up to BURST samples from the granted channel, then drains and tags every result.
module fir_channel_scheduler #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned BURST   = 8,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned FLUSH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    fir_channel_scheduler_if.master bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFlush = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic [7:0] BurstLast = 8'(BURST - 1);
    localparam logic [3:0] FlushLast = 4'(FLUSH - 1);

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [7:0]         smp_cnt_q, smp_cnt_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic               rin_q;
    logic [WIDTH-1:0]   din_q;
    logic               clr_n_q;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [LATENCY-1:0] tag_ch_q, tag_ch_d;
    logic               res_valid_q;
    logic               res_ch_q;
    logic [WIDTH-1:0]   res_data_q;

    logic             owner_valid;
    logic [WIDTH-1:0] owner_data;
    logic             xfer;
    logic             tags_empty;

    assign owner_valid = owner_q ? bus.s1_valid : bus.s0_valid;
    assign owner_data  = owner_q ? bus.s1_data : bus.s0_data;
    assign xfer        = en && (state_q == StRun) && owner_valid;
    // A strobe still in rin_q has not yet entered the tag pipeline but is in flight.
    assign tags_empty  = !rin_q && (tag_v_q == '0);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        smp_cnt_d   = smp_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.s0_valid || bus.s1_valid) begin
                    owner_d     = (bus.s0_valid && bus.s1_valid) ? ~last_q : bus.s1_valid;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    flush_cnt_d = '0;
                    smp_cnt_d   = '0;
                    state_d     = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            StRun: begin
                if (xfer) begin
                    smp_cnt_d = smp_cnt_q + 8'd1;
                    if (smp_cnt_q == BurstLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tags_empty) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tags enter one cycle after the transfer so they line up with the fir_rin strobe.
    always_comb begin
        tag_v_d     = '0;
        tag_ch_d    = '0;
        tag_v_d[0]  = rin_q;
        tag_ch_d[0] = owner_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_ch_d[i] = tag_ch_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            smp_cnt_q   <= '0;
            flush_cnt_q <= '0;
            rin_q       <= 1'b0;
            din_q       <= '0;
            clr_n_q     <= 1'b0;
            tag_v_q     <= '0;
            tag_ch_q    <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= 1'b0;
            res_data_q  <= '0;
        end else if (en) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            smp_cnt_q   <= smp_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rin_q       <= xfer;
            if (xfer) begin
                din_q <= owner_data;
            end
            clr_n_q     <= (state_d != StFlush);
            tag_v_q     <= tag_v_d;
            tag_ch_q    <= tag_ch_d;
            res_valid_q <= tag_v_q[LATENCY-1];
            res_ch_q    <= tag_ch_q[LATENCY-1];
            res_data_q  <= bus.fir_result;
        end
    end

    assign bus.s0_ready  = en && (state_q == StRun) && !owner_q && bus.s0_valid;
    assign bus.s1_ready  = en && (state_q == StRun) && owner_q && bus.s1_valid;
    assign bus.fir_en    = en && ((state_q == StRun) || (state_q == StDrain));
    assign bus.fir_rin   = en && rin_q;
    assign bus.fir_din   = din_q;
    assign bus.fir_clr_n = clr_n_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-shares one firFilter instance between two sample sources (channel 0, channel 1) using bursts. For each burst the scheduler grants the filter to one channel, clears the filter delay line, and streams up to BURST samples into it. It then drains the pipeline and tags every filter output with its channel number. It sits between the sample producers (counter-style sources) and firFilter, and drives the filter's clear, enable, rin and dataIn1.

Parameters:
WIDTH, 16, sample and result width in bits
BURST, 8, samples accepted per grant (1..255)
LATENCY, 4, cycles from a sample strobe on fir_rin to its result on fir_result (1..15)
FLUSH, 4, cycles fir_clr_n is held low before a burst (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
en  in  1  global enable; when low, all state and counters freeze and fir_en is low
s0_valid  in  1  channel 0 sample valid
s0_data  in  WIDTH  channel 0 sample
s0_ready  out  1  channel 0 sample accepted this cycle (valid & ready = transfer)
s1_valid  in  1  channel 1 sample valid
s1_data  in  WIDTH  channel 1 sample
s1_ready  out  1  channel 1 sample accepted this cycle
fir_clr_n  out  1  active-low clear to the filter's reset input
fir_en  out  1  filter enable
fir_rin  out  1  one-cycle strobe: fir_din holds a new sample
fir_din  out  WIDTH  sample to the filter's dataIn1
fir_result  in  WIDTH  filter output
res_valid  out  1  res_data is a result for res_ch
res_ch  out  1  channel the result belongs to
res_data  out  WIDTH  registered copy of fir_result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low at a clock edge), all registered outputs: s0_ready=0, s1_ready=0, fir_clr_n=0, fir_en=0, fir_rin=0, fir_din=0, res_valid=0, res_ch=0, res_data=0, busy=0. State goes to IDLE, the last-served pointer is set to 1 (channel 0 wins first), and all counters and the tag pipeline are cleared. Reset mid-burst aborts the burst; the next burst starts from IDLE with a FLUSH.
- States: IDLE, FLUSH, RUN, DRAIN.
- IDLE: if any sN_valid is high, grant owner = round-robin winner. If both channels are valid, the winner is the channel not served last; otherwise it is the single valid channel. Go to FLUSH. fir_clr_n=1 in IDLE.
- FLUSH: fir_clr_n=0 for exactly FLUSH cycles. Then go to RUN with the sample counter at 0.
- RUN: fir_en=1. The owner's ready is high, combinationally equal to owner's valid & en; the non-owner's ready is always 0. On each transfer: fir_din <= owner data, fir_rin <= 1 for the next cycle only, sample counter +1, and a tag bit is pushed into the tag pipeline. When the BURST-th sample is accepted, go to DRAIN. Gaps in valid are allowed and the filter is not strobed during a gap.
- DRAIN: the owner's ready is 0 and fir_en=1. Stay in DRAIN until the tag pipeline is empty, then go to IDLE, set last-served = owner, and fir_clr_n=1.
- Tag pipeline: LATENCY-deep shift of {valid, ch}, advancing only when en=1. Its output, registered one more stage with fir_result, drives res_valid, res_ch and res_data. End-to-end latency is fixed: the result for a sample whose fir_rin pulse occurs at cycle t appears on res_valid at cycle t+LATENCY+1.
- Only the owner is ever served during a burst. A new request from the other channel waits until IDLE.
- en=0: everything holds (state, counters, tag pipeline, res_* held). sN_ready=0, fir_rin=0, fir_en=0.
- Widths: counters are 8 bits (sample) and 4 bits (flush). No arithmetic on data; data passes through unchanged.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both valid high -> every output 0, busy=0. Release -> IDLE then FLUSH with fir_clr_n low for exactly 4 cycles, owner=ch0.
- Single burst: s0_valid continuously high, s0_data=1..8 -> s0_ready high for exactly 8 cycles, fir_din=1..8 on consecutive fir_rin pulses. With fir_result looped to fir_din through a 4-cycle delay model, res_valid pulses 8 times with res_ch=0 and res_data=1..8, each 5 cycles after its fir_rin. Then busy=0.
- Round-robin: both valid continuously -> bursts alternate ch0, ch1, ch0. s1_ready never high during a ch0 burst. res_ch sequence is 8×0, 8×1, 8×0.
- Gappy source: s1_valid toggles every other cycle, s0 idle -> 8 transfers over 16 cycles, no fir_rin during gaps, result order preserved.
- Freeze: drop en for 5 cycles mid-RUN after 3 samples -> no ready, no fir_rin, res_* held. Resume -> remaining 5 samples accepted and 8 total results emitted.
- Reset mid-DRAIN: assert rst 2 cycles into DRAIN -> res_valid=0 next cycle, no stale results afterward, and the next burst is preceded by a full FLUSH.
